// File: rtl/uart_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_link_ctrl
// Purpose  : Sequences one uart_protocol instance for two byte-stream
//            requesters (TX, round-robin packet arbitration) and one byte-
//            stream consumer (RX FIFO drain with per-byte error flags).
// Ports    : clk, reset_n            - clock, async active-low reset
//            req_valid/data/last/ready - two requester streams (TX side)
//            rx_valid/data/err/ready - received byte stream (RX side)
//            err_sticky, err_clear   - sticky error summary and its clear
//            write_data, bus_data_in, TX_status_register - uart TX side
//            read_data, bus_data_out, RX_status_register - uart RX side
// Revision : 1.0 - initial release
// ============================================================================
module uart_link_ctrl #(
    parameter int DATA_SIZE  = 8,
    parameter int MAX_PKT    = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               req_valid,
    input  logic [2*DATA_SIZE-1:0]   req_data,
    input  logic [1:0]               req_last,
    output logic [1:0]               req_ready,
    output logic                     rx_valid,
    output logic [DATA_SIZE-1:0]     rx_data,
    output logic [3:0]               rx_err,
    input  logic                     rx_ready,
    output logic [4:0]               err_sticky,
    input  logic                     err_clear,
    output logic                     write_data,
    output logic [DATA_SIZE-1:0]     bus_data_in,
    input  logic [7:0]               TX_status_register,
    output logic                     read_data,
    input  logic [DATA_SIZE-1:0]     bus_data_out,
    input  logic [7:0]               RX_status_register
);

    localparam int                c_CNT_W     = $clog2(MAX_PKT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_PKT);
    localparam logic [1:0]        c_WAIT_LAST = 2'(RD_LATENCY - 1);

    typedef enum logic [1:0] {T_IDLE = 2'd0, T_SEND = 2'd1, T_HOLD = 2'd2} tx_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_READ = 2'd1, R_WAIT = 2'd2, R_OUT = 2'd3} rx_state_t;

    // ------------------------------------------------------------------ TX
    tx_state_t            r_tx_state, w_tx_next;
    logic                 r_grant;
    logic                 r_rr_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_last;
    logic                 w_pick;
    logic                 w_tx_hs;
    logic                 w_pkt_end;
    logic [1:0]           w_req_ready;
    logic [DATA_SIZE-1:0] w_tx_data;
    logic                 w_sel_last;
    logic                 w_tx_full;

    assign w_tx_full  = TX_status_register[1];
    assign w_tx_data  = r_grant ? req_data[2*DATA_SIZE-1:DATA_SIZE] : req_data[DATA_SIZE-1:0];
    assign w_sel_last = r_grant ? req_last[1] : req_last[0];

    always_comb begin
        w_tx_next   = r_tx_state;
        w_req_ready = 2'b00;
        w_tx_hs     = 1'b0;
        w_pick      = r_rr_ptr;
        w_pkt_end   = 1'b0;
        case (r_tx_state)
            T_IDLE: begin
                // Search starts at the pointer so the requester that lost
                // the last arbitration wins the next collision.
                if (req_valid[r_rr_ptr]) begin
                    w_pick    = r_rr_ptr;
                    w_tx_next = T_SEND;
                end else if (req_valid[~r_rr_ptr]) begin
                    w_pick    = ~r_rr_ptr;
                    w_tx_next = T_SEND;
                end
            end
            T_SEND: begin
                w_req_ready[r_grant] = !w_tx_full;
                w_tx_hs              = req_valid[r_grant] && !w_tx_full;
                if (w_tx_hs) begin
                    w_tx_next = T_HOLD;
                end
            end
            T_HOLD: begin
                // One dead cycle after every write so the FIFO full flag
                // reflects the byte just pushed before the next handshake.
                w_pkt_end = r_last || (r_count == c_MAX_CNT);
                w_tx_next = w_pkt_end ? T_IDLE : T_SEND;
            end
            default: w_tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= T_IDLE;
            r_grant    <= 1'b0;
            r_rr_ptr   <= 1'b0;
            r_count    <= '0;
            r_last     <= 1'b0;
        end else begin
            r_tx_state <= w_tx_next;
            if (r_tx_state == T_IDLE && w_tx_next == T_SEND) begin
                r_grant <= w_pick;
            end
            if (w_tx_hs) begin
                r_count <= r_count + c_CNT_W'(1);
                r_last  <= w_sel_last;
            end
            if (r_tx_state == T_HOLD && w_pkt_end) begin
                r_rr_ptr <= ~r_grant;
                r_count  <= '0;
            end
        end
    end

    assign req_ready   = w_req_ready;
    assign write_data  = w_tx_hs;
    assign bus_data_in = w_tx_hs ? w_tx_data : '0;

    // ------------------------------------------------------------------ RX
    rx_state_t            r_rx_state, w_rx_next;
    logic [1:0]           r_wait_cnt;
    logic [DATA_SIZE-1:0] r_rx_data;
    logic [3:0]           r_rx_err;
    logic                 w_capture;

    always_comb begin
        w_rx_next = r_rx_state;
        w_capture = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                if (!RX_status_register[2] && !RX_status_register[7]) begin
                    w_rx_next = R_READ;
                end
            end
            R_READ: w_rx_next = R_WAIT;
            R_WAIT: begin
                // R_WAIT spans RD_LATENCY cycles; the last one is the cycle
                // in which the FIFO read data is valid on bus_data_out.
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_capture = 1'b1;
                    w_rx_next = R_OUT;
                end
            end
            R_OUT: begin
                if (rx_ready) begin
                    w_rx_next = R_IDLE;
                end
            end
            default: w_rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= R_IDLE;
            r_wait_cnt <= 2'd0;
            r_rx_data  <= '0;
            r_rx_err   <= 4'd0;
        end else begin
            r_rx_state <= w_rx_next;
            if (r_rx_state == R_READ) begin
                // Status flags describe the byte being popped right now.
                r_rx_err   <= RX_status_register[6:3];
                r_wait_cnt <= 2'd0;
            end else if (r_rx_state == R_WAIT && !w_capture) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end
            if (w_capture) begin
                r_rx_data <= bus_data_out;
            end
        end
    end

    assign read_data = (r_rx_state == R_READ);
    assign rx_valid  = (r_rx_state == R_OUT);
    assign rx_data   = r_rx_data;
    assign rx_err    = r_rx_err;

    // -------------------------------------------------------- sticky errors
    logic [4:0] r_err_sticky;
    logic       w_tx_err_set;

    assign w_tx_err_set = (r_tx_state == T_HOLD) && TX_status_register[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_sticky <= 5'd0;
        end else if (err_clear) begin
            r_err_sticky <= 5'd0;
        end else begin
            r_err_sticky <= r_err_sticky | {w_tx_err_set, (w_capture ? r_rx_err : 4'd0)};
        end
    end

    assign err_sticky = r_err_sticky;

    // Status bits this controller has no use for.
    logic w_unused_status;
    assign w_unused_status = ^{TX_status_register[7:3], RX_status_register[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_uart_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_link_ctrl
// Purpose  : Directed self-checking bench for uart_link_ctrl (MAX_PKT = 4,
//            RD_LATENCY = 1): arbitration, packet split, TX backpressure,
//            TX/RX error capture, RX drain and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_link_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [3:0]  rx_err;
    logic        rx_ready;
    logic [4:0]  err_sticky;
    logic        err_clear;
    logic        write_data;
    logic [7:0]  bus_data_in;
    logic [7:0]  TX_status_register;
    logic        read_data;
    logic [7:0]  bus_data_out;
    logic [7:0]  RX_status_register;

    uart_link_ctrl #(.DATA_SIZE(8), .MAX_PKT(4), .RD_LATENCY(1)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_last           (req_last),
        .req_ready          (req_ready),
        .rx_valid           (rx_valid),
        .rx_data            (rx_data),
        .rx_err             (rx_err),
        .rx_ready           (rx_ready),
        .err_sticky         (err_sticky),
        .err_clear          (err_clear),
        .write_data         (write_data),
        .bus_data_in        (bus_data_in),
        .TX_status_register (TX_status_register),
        .read_data          (read_data),
        .bus_data_out       (bus_data_out),
        .RX_status_register (RX_status_register)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Source queues per requester: {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    // Observed write log: data, source requester, cycle
    logic [7:0] log_data[$];
    int         log_src[$];
    int         log_cyc[$];
    logic [8:0] expq[$];

    int viol_full  = 0;
    int viol_ready = 0;
    int viol_both  = 0;
    int seen_r1    = 0;
    int rd_pulses  = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester driver: pops on a handshake seen at the preceding negedge,
    // then presents the current head of each queue just after the edge.
    initial begin
        logic [1:0] hs;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        req_last  = 2'b00;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            if (hs[0] && q0.size() > 0) void'(q0.pop_front());
            if (hs[1] && q1.size() > 0) void'(q1.pop_front());
            req_valid[0]   = (q0.size() > 0);
            req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
            req_last[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
            req_valid[1]   = (q1.size() > 0);
            req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
            req_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
        end
    end

    // Output monitor
    initial forever begin
        @(negedge clk);
        if (write_data) begin
            log_data.push_back(bus_data_in);
            log_src.push_back(req_ready[1] ? 1 : 0);
            log_cyc.push_back(cyc);
        end
        if (write_data && TX_status_register[1]) viol_full++;
        if (TX_status_register[1] && req_ready != 2'b00) viol_ready++;
        if (req_ready == 2'b11) viol_both++;
        if (req_ready[1]) seen_r1++;
        if (read_data) rd_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        if (r == 0) q0.push_back({l, d});
        else        q1.push_back({l, d});
    endtask

    function automatic logic [8:0] log_ent(input int i);
        if (i < log_data.size()) return {log_src[i][0], log_data[i]};
        return 9'h1FF;
    endfunction

    function automatic int log_c(input int i);
        if (i < log_cyc.size()) return log_cyc[i];
        return 32'h7FFF0000;
    endfunction

    task automatic wait_log(input int n, input string tag);
        int k;
        k = 0;
        while (log_data.size() < n && k < 200) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(log_data.size() >= n), 32'd1);
    endtask

    task automatic wait_sig_rd(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!read_data && k < 50);
        chk(tag, 32'(read_data), 32'd1);
    endtask

    task automatic wait_sig_wr(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!write_data && k < 50);
        chk(tag, 32'(write_data), 32'd1);
    endtask

    task automatic check_seq(input int base, input string tag);
        for (int i = 0; i < expq.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(log_ent(base + i)), 32'(expq[i]));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_write_data"},  32'(write_data),  32'd0);
        chk({tag, "_req_ready"},   32'(req_ready),   32'd0);
        chk({tag, "_bus_data_in"}, 32'(bus_data_in), 32'd0);
        chk({tag, "_read_data"},   32'(read_data),   32'd0);
        chk({tag, "_rx_valid"},    32'(rx_valid),    32'd0);
        chk({tag, "_rx_data"},     32'(rx_data),     32'd0);
        chk({tag, "_rx_err"},      32'(rx_err),      32'd0);
        chk({tag, "_err_sticky"},  32'(err_sticky),  32'd0);
    endtask

    initial begin
        int base;
        int nfull;
        int clr_cyc;
        int rd_base;

        reset_n            = 1'b1;
        rx_ready           = 1'b0;
        err_clear          = 1'b0;
        TX_status_register = 8'h00;
        RX_status_register = 8'h04;
        bus_data_out       = 8'h00;
        #1 reset_n = 1'b0;
        #1 chk_zero("reset");
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Single requester, two-byte packet
        seen_r1 = 0;
        push(0, 8'hA5, 1'b0);
        push(0, 8'h3C, 1'b1);
        wait_log(2, "t1_done");
        expq = '{9'h0A5, 9'h03C};
        check_seq(0, "t1");
        chk("t1_spacing", 32'(log_c(1) - log_c(0)), 32'd2);
        chk("t1_ready1_quiet", 32'(seen_r1), 32'd0);

        // Collision after req0 finished a packet: req1 wins first
        base = log_data.size();
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
        push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b0); push(1, 8'h22, 1'b1);
        wait_log(base + 6, "coll_done");
        expq = '{9'h120, 9'h121, 9'h122, 9'h010, 9'h011, 9'h012};
        check_seq(base, "coll");

        // Forced re-arbitration after MAX_PKT = 4 bytes
        base = log_data.size();
        for (int i = 0; i < 6; i++) push(0, 8'(8'h30 + i), (i == 5));
        tick(2);
        push(1, 8'h40, 1'b0); push(1, 8'h41, 1'b1);
        wait_log(base + 8, "maxpkt_done");
        expq = '{9'h030, 9'h031, 9'h032, 9'h033, 9'h140, 9'h141, 9'h034, 9'h035};
        check_seq(base, "maxpkt");

        // TX FIFO full for 20 cycles mid-packet
        base = log_data.size();
        for (int i = 0; i < 6; i++) push(0, 8'(8'h50 + i), (i == 5));
        wait_log(base + 2, "full_pre");
        nfull = log_data.size();
        TX_status_register = 8'h02;
        @(negedge clk);
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_write", 32'(write_data), 32'd0);
        tick(20);
        chk("full_no_bytes", 32'(log_data.size()), 32'(nfull));
        TX_status_register = 8'h00;
        clr_cyc = cyc;
        wait_log(base + 6, "full_done");
        chk("full_resume", 32'((log_c(nfull) - clr_cyc) <= 1), 32'd1);
        expq = '{9'h050, 9'h051, 9'h052, 9'h053, 9'h054, 9'h055};
        check_seq(base, "full");
        chk("full_viol_write", 32'(viol_full), 32'd0);
        chk("full_viol_ready", 32'(viol_ready), 32'd0);
        chk("both_ready_never", 32'(viol_both), 32'd0);
        tick(2);

        // TX write error flagged in T_HOLD
        base = log_data.size();
        TX_status_register = 8'h01;
        push(0, 8'h60, 1'b1);
        wait_log(base + 1, "txerr_done");
        tick(2);
        TX_status_register = 8'h00;
        @(negedge clk);
        chk("txerr_sticky", 32'(err_sticky), 32'h10);
        chk("txerr_byte", 32'(log_ent(base)), 32'h060);
        tick(1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        @(negedge clk);
        chk("txerr_cleared", 32'(err_sticky), 32'd0);

        // RX byte with parity error, consumer stalls
        tick(1);
        rd_base = rd_pulses;
        RX_status_register = 8'h08;
        wait_sig_rd("rx_pulse");
        @(negedge clk);
        bus_data_out = 8'h5A;
        chk("rx_not_yet_valid", 32'(rx_valid), 32'd0);
        chk("rx_pulse_width", 32'(read_data), 32'd0);
        @(negedge clk);
        bus_data_out = 8'hFF;
        chk("rx_valid", 32'(rx_valid), 32'd1);
        chk("rx_data", 32'(rx_data), 32'h5A);
        chk("rx_err", 32'(rx_err), 32'h1);
        tick(8);
        @(negedge clk);
        chk("rx_one_pulse", 32'(rd_pulses - rd_base), 32'd1);
        chk("rx_held_valid", 32'(rx_valid), 32'd1);
        chk("rx_held_data", 32'(rx_data), 32'h5A);
        chk("rx_sticky_parity", 32'(err_sticky), 32'h01);
        tick(1);
        RX_status_register = 8'h04;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        @(negedge clk);
        chk("rx_drained", 32'(rx_valid), 32'd0);
        chk("rx_sticky_kept", 32'(err_sticky), 32'h01);
        tick(1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        @(negedge clk);
        chk("rx_sticky_cleared", 32'(err_sticky), 32'd0);

        // Reset during T_HOLD (req1 packet, pointer currently at req1)
        tick(1);
        push(1, 8'h70, 1'b0);
        push(1, 8'h71, 1'b1);
        wait_sig_wr("txrst_first_write");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("txrst");
        q0.delete();
        q1.delete();
        tick(2);
        base = log_data.size();
        reset_n = 1'b1;
        tick(3);
        chk("txrst_no_write", 32'(log_data.size()), 32'(base));
        push(0, 8'h80, 1'b1);
        push(1, 8'h90, 1'b1);
        wait_log(base + 2, "txrst_arb_done");
        expq = '{9'h080, 9'h190};
        check_seq(base, "txrst_arb");

        // Reset during R_WAIT
        tick(2);
        rd_base = rd_pulses;
        bus_data_out = 8'h77;
        RX_status_register = 8'h08;
        wait_sig_rd("rxrst_pulse");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("rxrst");
        RX_status_register = 8'h04;
        tick(2);
        reset_n = 1'b1;
        tick(4);
        @(negedge clk);
        chk("rxrst_no_valid", 32'(rx_valid), 32'd0);
        chk("rxrst_one_pulse", 32'(rd_pulses - rd_base), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
